// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer and its response FIFO.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int CMD_A_LSB   = 0;
  localparam int CMD_B_LSB   = 3;
  localparam int CMD_SEL_LSB = 6;

  localparam int RSP_W = 9;

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  function automatic logic div_by_zero(input logic [1:0] sel, input logic [2:0] b);
    return (sel == OP_DIV) && (b == 3'd0);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; head and valid come straight from registered storage.
module alu_rsp_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          pop_ok, push_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  // A push into a full FIFO is only safe when the head leaves on the same edge.
  assign push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives operands to the 3-bit arithmetic unit, waits a settle window, and
// queues {err, sel, result} responses for the host.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [1:0] alu_sel,
  input  logic [5:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [5:0] rsp_data,
  output logic [1:0] rsp_op,
  output logic       rsp_err,
  output logic       busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] a_q, a_d, b_q, b_d;
  logic [1:0] sel_q, sel_d;
  logic       push;
  logic [RSP_W-1:0] push_data, head;
  logic [CW-1:0]    fifo_count;

  // Only one command is ever in flight, so admitting while count < depth
  // guarantees its push always finds a free slot.
  assign cmd_ready = !rst && (state_q == S_IDLE) && (fifo_count < CW'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d     = cmd_data[CMD_A_LSB +: 3];
          b_d     = cmd_data[CMD_B_LSB +: 3];
          sel_d   = cmd_data[CMD_SEL_LSB +: 2];
          cnt_d   = SETTLE_M1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == 4'd0) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
    end
  end

  assign push_data = {div_by_zero(sel_q, b_q), sel_q, alu_result};

  alu_rsp_fifo #(.W(RSP_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (rsp_ready),
    .head_o  (head),
    .valid_o (rsp_valid),
    .count_o (fifo_count)
  );

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_sel  = sel_q;
  assign rsp_err  = head[8];
  assign rsp_op   = head[7:6];
  assign rsp_data = head[5:0];
  assign busy     = (state_q == S_DRIVE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: SETTLE=1 instance with an ALU model, SETTLE=3 instance with a scripted result.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid1 = 1'b0, cmd_valid3 = 1'b0;
  logic [7:0] cmd_data1 = '0, cmd_data3 = '0;
  logic       rsp_ready1 = 1'b0, rsp_ready3 = 1'b0;
  logic [5:0] res1, res3 = '0;
  logic       cmd_ready1, cmd_ready3, rsp_valid1, rsp_valid3, rsp_err1, rsp_err3, busy1, busy3;
  logic [2:0] alu_a1, alu_b1, alu_a3, alu_b3;
  logic [1:0] alu_sel1, alu_sel3, rsp_op1, rsp_op3;
  logic [5:0] rsp_data1, rsp_data3;

  int n_tests = 0;
  int n_fail  = 0;

  alu_op_sequencer #(.SETTLE(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_data(cmd_data1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_result(res1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_op(rsp_op1),
    .rsp_err(rsp_err1), .busy(busy1));

  alu_op_sequencer #(.SETTLE(3), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_data(cmd_data3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_result(res3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_op(rsp_op3),
    .rsp_err(rsp_err3), .busy(busy3));

  // Arithmetic unit model; divide by zero saturates to all ones.
  always_comb begin
    res1 = 6'd0;
    case (alu_sel1)
      2'b00: res1 = {3'b0, alu_a1} + {3'b0, alu_b1};
      2'b01: res1 = {3'b0, alu_a1} - {3'b0, alu_b1};
      2'b10: res1 = {3'b0, alu_a1} * {3'b0, alu_b1};
      2'b11: res1 = (alu_b1 == 3'd0) ? 6'd63 : {3'b0, alu_a1} / {3'b0, alu_b1};
      default: res1 = 6'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and returns 1 ns after its accept edge.
  task automatic send(input int which, input logic [7:0] cmd);
    int n = 0;
    if (which == 1) begin cmd_valid1 = 1'b1; cmd_data1 = cmd; end
    else            begin cmd_valid3 = 1'b1; cmd_data3 = cmd; end
    while (((which == 1) ? cmd_ready1 : cmd_ready3) !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    tick();
    cmd_valid1 = 1'b0;
    cmd_valid3 = 1'b0;
  endtask

  task automatic pop1();
    rsp_ready1 = 1'b1;
    tick();
    rsp_ready1 = 1'b0;
  endtask

  logic [7:0] bp_cmd [5];
  logic [5:0] bp_res [5];
  logic [1:0] bp_op  [5];
  logic       stayed_low;

  initial begin
    bp_cmd = '{8'h09, 8'h52, 8'h8B, 8'hD6, 8'h24};
    bp_res = '{6'd2, 6'd0, 6'd3, 6'd3, 6'd8};
    bp_op  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #2;
    check("rst_cmd_ready", cmd_ready1, 0);
    check("rst_rsp_valid", rsp_valid1, 0);
    check("rst_alu_a", alu_a1, 0);
    check("rst_busy", busy1, 0);
    #6 rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready1, 1);

    // Add, SETTLE=1
    send(1, 8'h1D);
    check("add_busy", busy1, 1);
    check("add_alu_a", alu_a1, 5);
    check("add_alu_b", alu_b1, 3);
    check("add_cmd_ready_drive", cmd_ready1, 0);
    check("add_not_yet_valid", rsp_valid1, 0);
    tick();
    check("add_rsp_valid", rsp_valid1, 1);
    check("add_rsp_data", rsp_data1, 8);
    check("add_rsp_op", rsp_op1, 0);
    check("add_rsp_err", rsp_err1, 0);
    check("add_busy_done", busy1, 0);
    pop1();
    check("add_popped", rsp_valid1, 0);

    // Multiply
    send(1, 8'hBF);
    tick();
    check("mul_rsp_data", rsp_data1, 49);
    check("mul_rsp_op", rsp_op1, 2);
    check("mul_rsp_err", rsp_err1, 0);
    pop1();

    // Divide by zero
    send(1, 8'hC5);
    tick();
    check("div0_rsp_err", rsp_err1, 1);
    check("div0_rsp_data", rsp_data1, 63);
    check("div0_rsp_op", rsp_op1, 3);
    pop1();
    check("div0_popped", rsp_valid1, 0);

    // Backpressure: four fill the FIFO, the fifth must wait for a pop
    for (int i = 0; i < 4; i++) send(1, bp_cmd[i]);
    tick();
    cmd_valid1 = 1'b1;
    cmd_data1  = bp_cmd[4];
    stayed_low = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready1 !== 1'b0) stayed_low = 1'b0;
      tick();
    end
    check("bp_cmd_ready_low", stayed_low, 1);
    check("bp_not_busy", busy1, 0);
    check("bp_head0_data", rsp_data1, bp_res[0]);
    cmd_valid1 = 1'b0;
    pop1();
    send(1, bp_cmd[4]);
    tick();
    for (int i = 1; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), rsp_valid1, 1);
      check($sformatf("bp_data%0d", i), rsp_data1, bp_res[i]);
      check($sformatf("bp_op%0d", i), rsp_op1, bp_op[i]);
      pop1();
    end
    check("bp_drained", rsp_valid1, 0);

    // Settle window, SETTLE=3: only the result present before the 3rd edge counts
    res3 = 6'd11;
    send(3, 8'h1D);
    res3 = 6'd20;
    check("settle_busy_e0", busy3, 1);
    check("settle_a_e0", alu_a3, 5);
    tick();
    res3 = 6'd30;
    check("settle_a_e1", alu_a3, 5);
    check("settle_b_e1", alu_b3, 3);
    check("settle_valid_e1", rsp_valid3, 0);
    tick();
    res3 = 6'd42;
    check("settle_sel_e2", alu_sel3, 0);
    check("settle_valid_e2", rsp_valid3, 0);
    check("settle_busy_e2", busy3, 1);
    tick();
    res3 = 6'd7;
    check("settle_valid_e3", rsp_valid3, 1);
    check("settle_data_e3", rsp_data3, 42);
    check("settle_busy_e3", busy3, 0);
    check("settle_a_hold", alu_a3, 5);

    // Reset abort with two entries queued and a third in flight
    send(1, 8'h1D);
    tick();
    send(1, 8'hBF);
    tick();
    send(1, 8'hC5);
    check("abort_in_drive", busy1, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy1, 0);
    check("abort_rsp_valid", rsp_valid1, 0);
    check("abort_rsp_data", rsp_data1, 0);
    check("abort_rsp_op", rsp_op1, 0);
    check("abort_rsp_err", rsp_err1, 0);
    check("abort_alu_a", alu_a1, 0);
    check("abort_alu_b", alu_b1, 0);
    check("abort_alu_sel", alu_sel1, 0);
    check("abort_cmd_ready", cmd_ready1, 0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_release_ready", cmd_ready1, 1);
    check("abort_no_stale", rsp_valid1, 0);
    tick();
    check("abort_no_resp", rsp_valid1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-side initiator for the 3-bit arithmetic unit. It accepts packed operation commands over a valid/ready port and drives A, B and sel to the arithmetic unit. It holds those operands for a programmable settle window, then samples the 6-bit result. Results are queued in a small response FIFO with op tag and divide-by-zero flag, so a host-side reader can drain them at its own pace.

## Interface
Parameters:
- `SETTLE`, 1: cycles operands are held before `alu_result` is sampled (legal 1..15).
- `FIFO_DEPTH`, 4: response FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_data`  in  8  `[2:0]` A, `[5:3]` B, `[7:6]` sel.
- `alu_a`  out  3  operand A to arithmetic unit.
- `alu_b`  out  3  operand B to arithmetic unit.
- `alu_sel`  out  2  op select: 00 add, 01 sub, 10 mul, 11 div.
- `alu_result`  in  6  combinational result from arithmetic unit.
- `rsp_valid`  out  1  FIFO non-empty.
- `rsp_ready`  in  1  pop head when `rsp_valid & rsp_ready`.
- `rsp_data`  out  6  head result.
- `rsp_op`  out  2  head sel tag.
- `rsp_err`  out  1  head flag: sel==11 and B==0.
- `busy`  out  1  high in DRIVE state.

## Operation
- FSM states: IDLE, DRIVE.
- IDLE to DRIVE occurs on a cmd handshake.
  - `cmd_data` fields are latched into `alu_a/alu_b/alu_sel`.
  - The settle counter loads `SETTLE-1`.
- In DRIVE, the counter decrements each edge.
  - On the edge where the counter is 0, `alu_result` is sampled and an entry `{err, sel, result}` (9 bits) is pushed.
  - The FSM then returns to IDLE.
- `cmd_ready = (state==IDLE) & (count < FIFO_DEPTH)`. Gating on count guarantees a push never finds the FIFO full; no result is ever dropped.
- `alu_*` outputs hold their last operands in IDLE and never change while in DRIVE.
- `rsp_err` is computed from the latched operands, not from `alu_result`. `rsp_data` carries `alu_result` unmodified.
- FIFO ordering is strict FIFO. Push and pop in the same cycle leave the count unchanged and are legal at any fill level.
- Reset mid-operation aborts the in-flight command and clears the FIFO. The aborted command produces no response.

## Timing
- Reset values:
  - `alu_a/alu_b/alu_sel` = 0; `rsp_valid`, `rsp_data`, `rsp_op`, `rsp_err`, `busy` = 0.
  - FSM in IDLE with count 0.
  - `cmd_ready` = 0 while `rst` is high, and 1 from the first cycle after deassertion.
- Latency, accept to push: `SETTLE` edges after the accept edge. With `SETTLE=1`, accept at edge 0, push at edge 1, `rsp_valid` high after edge 1 if the FIFO was empty.
- Throughput: one command per `SETTLE+1` cycles; `cmd_ready` is low during DRIVE.
- `rsp_valid` and head fields are registered FIFO outputs. The head is valid the cycle after push into an empty FIFO.
- The count register width is clog2(`FIFO_DEPTH`+1). The FIFO pointers wrap modulo `FIFO_DEPTH`.

## Structure
- Package `alu_seq_pkg`:
  - op constants `OP_ADD/OP_SUB/OP_MUL/OP_DIV`;
  - state enum `{S_IDLE, S_DRIVE}`;
  - `cmd_data` field offsets;
  - response entry width (9).
- Sub-module `alu_rsp_fifo`: synchronous FIFO, parameterized width/depth, with push/pop/count/head outputs.
- The top-level module contains the FSM, settle counter, operand registers and err logic.

## Test plan
- Reset abort:
  - Stimulus: `rst` pulse mid-DRIVE with 2 entries queued.
  - Required: all outputs 0 immediately; `cmd_ready`=1 the cycle after release; no stale `rsp_valid`.
- Add, `SETTLE=1`:
  - Stimulus: `cmd_data`=0x1D (A=5, B=3, add); ALU model returns 8.
  - Required: `rsp_valid` after edge 1 with `rsp_data`=8, `rsp_op`=0, `rsp_err`=0.
- Multiply:
  - Stimulus: `cmd_data`=0xBF (7×7).
  - Required: `rsp_data`=49, `rsp_op`=2.
- Divide by zero:
  - Stimulus: `cmd_data`=0xC5 (A=5, B=0, div); model returns 63.
  - Required: `rsp_err`=1, `rsp_data`=63, `rsp_op`=3.
- Backpressure:
  - Stimulus: `rsp_ready`=0, 5 commands offered.
  - Required: 4 accepted and `cmd_ready` stays low; after one pop, the 5th is accepted; responses drain in issue order.
- Settle window, `SETTLE=3`:
  - Stimulus: model result changes on cycles 1–2.
  - Required: `alu_*` stable 3 cycles; only the value present before the 3rd edge is pushed.
